// File: rtl/button_debounce_bank.sv
// Per-channel 2-flop synchroniser plus debounce FSM giving a clean level and a one-cycle press pulse.
// Optional auto-repeat pulses while held: define DEBOUNCE_AUTOREPEAT_EN.
module button_debounce_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned CNT_W         = 19,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 20000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_pulse,
    output logic                any_pulse
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Static configuration sanity checks, evaluated at elaboration only.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debounce_bank: STABLE_CYCLES must be at least 2");
    end
    if ((64'(STABLE_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
        $error("button_debounce_bank: CNT_W too narrow for STABLE_CYCLES");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
        $error("button_debounce_bank: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [1:0]          state_q [CHANNELS];
    logic [1:0]          state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] pulse_d;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [31:0] REP_FIRST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] REP_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [31:0] rep_q [CHANNELS];
    logic [31:0] rep_d [CHANNELS];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            pulse_d[i] = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_d[i]   = rep_q[i];
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HELD;
                        level_d[i] = 1'b1;
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        rep_d[i]   = '0;
`endif
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        // Reload lands exactly REPEAT_PERIOD cycles before the next fire point.
                        if (rep_q[i] == REP_FIRST) begin
                            pulse_d[i] = 1'b1;
                            rep_d[i]   = REP_RELOAD;
                        end else begin
                            rep_d[i]   = rep_q[i] + 32'd1;
                        end
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_IDLE;
                        level_d[i] = 1'b0;
                        cnt_d[i]   = '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        rep_d[i]   = '0;
`endif
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef DEBOUNCE_AUTOREPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench: a run-length reference model predicts level/pulse each cycle, a monitor compares.
module tb_button_debounce_bank;

    localparam int unsigned CH     = 4;
    localparam int unsigned STABLE = 4;
    localparam int unsigned RDELAY = 10;
    localparam int unsigned RPER   = 3;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pul;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_pulse;
    logic          any_pulse;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference state: accepted level, run of samples disagreeing with it, sync delay line, held time.
    bit          m_lvl [CH];
    int unsigned m_run [CH];
    bit          m_sh1 [CH];
    bit          m_sh2 [CH];
    int unsigned m_t   [CH];

    button_debounce_bank #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (3),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_PERIOD(RPER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                m_lvl[c] = 1'b0; m_run[c] = 0; m_sh1[c] = 1'b0; m_sh2[c] = 1'b0; m_t[c] = 0;
            end
            q.delete();
        end else begin : model_step
            exp_t e;
            bit   s;
            bit   p;
            for (int c = 0; c < CH; c++) begin
                s = m_sh2[c];
                m_sh2[c] = m_sh1[c];
                m_sh1[c] = btn_raw[c];
                p = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                if (m_lvl[c] && m_run[c] == 0 && s) begin
                    m_t[c]++;
                    if (m_t[c] == RDELAY || (m_t[c] > RDELAY && (m_t[c] - RDELAY) % RPER == 0))
                        p = 1'b1;
                end
`endif
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == STABLE) begin
                        m_lvl[c] = s;
                        m_run[c] = 0;
                        m_t[c]   = 0;
                        if (s) p = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                e.lvl[c] = m_lvl[c];
                e.pul[c] = p;
            end
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && q.size() > 0) begin
            e = q.pop_front();
            chk("level", 32'(btn_level), 32'(e.lvl));
            chk("pulse", 32'(btn_pulse), 32'(e.pul));
            chk("any_pulse", 32'(any_pulse), 32'(|e.pul));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        tick(3);
        chk("reset_level", 32'(btn_level), 32'd0);
        chk("reset_pulse", 32'(btn_pulse), 32'd0);
        chk("reset_any", 32'(any_pulse), 32'd0);
        rst = 1'b1;
        tick(3);

        // Clean press on ch0: accept STABLE+1 edges after capture.
        btn_raw = 4'b0001;
        tick(5);
        chk("press_early_level", 32'(btn_level[0]), 32'd0);
        tick(1);
        chk("press_level", 32'(btn_level[0]), 32'd1);
        chk("press_pulse", 32'(btn_pulse), 32'b0001);
        tick(1);
        chk("press_pulse_width", 32'(btn_pulse), 32'd0);
        tick(20);
        btn_raw = 4'b0000;
        tick(10);

        // Bounce on ch1: three-high one-low never accumulates enough stable samples.
        for (int k = 0; k < 40; k++) begin
            btn_raw[1] = (k % 4) != 3;
            tick(1);
        end
        btn_raw[1] = 1'b0;
        chk("bounce_level", 32'(btn_level[1]), 32'd0);
        tick(8);

        // Release bounce on ch2.
        btn_raw[2] = 1'b1;
        tick(12);
        btn_raw[2] = 1'b0;
        tick(3);
        btn_raw[2] = 1'b1;
        tick(1);
        btn_raw[2] = 1'b0;
        tick(5);
        chk("release_hold_level", 32'(btn_level[2]), 32'd1);
        tick(5);
        chk("release_level", 32'(btn_level[2]), 32'd0);
        tick(4);

        // Simultaneous press on ch0 and ch3.
        btn_raw = 4'b1001;
        tick(6);
        chk("simul_pulse", 32'(btn_pulse), 32'b1001);
        chk("simul_any", 32'(any_pulse), 32'd1);
        tick(1);
        chk("simul_any_width", 32'(any_pulse), 32'd0);
        btn_raw = 4'b0000;
        tick(10);

        // Reset during ch0 press wait while ch2 is held.
        btn_raw = 4'b0100;
        tick(10);
        btn_raw = 4'b0101;
        tick(4);
        rst = 1'b0;
        #1;
        chk("midrst_level", 32'(btn_level), 32'd0);
        chk("midrst_pulse", 32'(btn_pulse), 32'd0);
        chk("midrst_any", 32'(any_pulse), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(5);
        chk("postrst_early", 32'(btn_pulse), 32'd0);
        tick(1);
        chk("postrst_pulse", 32'(btn_pulse), 32'b0101);
        tick(5);
        btn_raw = 4'b0000;
        tick(10);

        // Long hold on ch0 exercises auto-repeat when that feature is built in.
        btn_raw = 4'b0001;
        tick(36);
        btn_raw = 4'b0000;
        tick(12);

        // Randomised bouncy activity on all channels.
        for (int k = 0; k < 500; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            tick(1);
        end
        btn_raw = 4'b0000;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
